load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit that sits between the single-cycle datapath's ALU/register-file outputs and a handshaked, word-wide data memory bus. It takes the byte address, the store data and the access size, and performs byte-lane alignment, byte-enable generation and load sign/zero extension. It holds the processor with `stall` until the bus access completes.

## Interface
- `TIMEOUT`, 15: maximum REQ cycles without `mem_ack` before the access is abandoned (1..255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request from the controller.
- `wr_en` in 1: store request from the controller.
- `funct3` in 3: access size. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU. Other codes are treated as W.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load result to the write-back mux.
- `stall` out 1: hold PC and suppress register write while high.
- `misalign` out 1: current access is misaligned and was dropped.
- `timeout` out 1: current access was abandoned by the timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion.
- `mem_rdata` in 32: bus read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `rd_en|wr_en` with an aligned address, capture addr, funct3, we (= `wr_en`; `wr_en` wins if both are high), be and wdata. Go to REQ.
  - Misaligned cases: H/HU with addr[0]=1, or W with addr[1:0]≠0. Stay in IDLE; `misalign`=1 combinationally; `stall`=0; `rdata`=0; no bus access.
- REQ:
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` come from the captured registers and stay stable.
  - On `mem_ack`, capture `mem_rdata` and go to DONE.
  - Otherwise increment the timeout counter. When it equals `TIMEOUT`, set the timeout flag and go to DONE with the captured word = 0.
- DONE:
  - `stall`=0; `rdata` is valid.
  - `timeout` is high for this cycle only if the access timed out.
  - Unconditionally return to IDLE next cycle. The counter and flag clear.
- `stall` = (IDLE & (rd_en|wr_en) & aligned) | REQ.
- Byte enables:
  - B: `0001 << addr[1:0]`.
  - H: `0011 << {addr[1],1'b0}`.
  - W: `1111`.
- Store data:
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: wdata.
- Load extraction from the captured word, using captured addr[1:0]:
  - B/H: sign-extend the selected lane to 32 bits.
  - BU/HU: zero-extend.
  - W: the full word.
  - `rdata`=0 outside DONE and for stores.
- `mem_ack` is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, counter 0, all captured registers 0.
  - Outputs: `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `timeout`=0.
  - `stall` and `misalign` are combinational from the inputs.
- Minimum access is 3 cycles:
  - C0: IDLE, stall=1.
  - C1: REQ, ack=1.
  - C2: DONE, stall=0; the PC advances at the end of C2.
- An ack after k wait cycles adds k cycles.
- A timeout access lasts `TIMEOUT`+2 cycles.
- The same instruction is presented throughout the stall. DONE→IDLE guarantees it is not re-issued.
- `rst` asserted in REQ: IDLE and `mem_req`=0 after that edge. A late `mem_ack` is ignored.
- Back-to-back memory instructions:
  - The next access is accepted in the IDLE cycle immediately after DONE.
  - Bus occupancy: one access in flight at most.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack in first REQ cycle -> `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `mem_we`=1. `stall` is high for exactly 2 cycles.
- LB addr=0x103, mem_rdata=0x80FF_1234 -> `rdata`=0xFFFFFF80 in DONE. The same access with LBU gives 0x00000080.
- SH addr=0x22, wdata=0x0000ABCD -> `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x20.
- LW addr=0x101 -> `misalign`=1, `stall`=0, `mem_req` stays 0, `rdata`=0.
- LH addr=0x40 with ack withheld, `TIMEOUT`=15 -> `mem_req` high for 15 cycles, then DONE with `timeout`=1 and `rdata`=0. The return to IDLE follows.
- Load with ack delayed 3 cycles, `rst` pulsed in the 2nd REQ cycle -> IDLE and `mem_req`=0 the next cycle. The later ack produces no DONE.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte-lane alignment, byte enables and load extension
// between the datapath and a handshaked word-wide data bus; stalls the core per access.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

  function automatic size_e size_of(input logic [2:0] f3);
    size_e sz;
    case (f3)
      3'b000, 3'b100: sz = SZ_B;
      3'b001, 3'b101: sz = SZ_H;
      default:        sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (size_of(f3))
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (size_of(f3))
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (size_of(f3))
      SZ_B:    d = {4{wd[7:0]}};
      SZ_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then extend according to the access type.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        to_q, to_d;

  logic        access_s;
  logic        bad_s;
  logic [7:0]  cnt_inc_s;

  assign access_s  = rd_en | wr_en;
  assign bad_s     = is_misaligned(funct3, addr[1:0]);
  assign cnt_inc_s = cnt_q + 8'd1;

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (access_s && !bad_s) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
          addr_d  = addr;
          f3_d    = funct3;
          we_d    = wr_en;
          be_d    = byte_en(funct3, addr[1:0]);
          wdata_d = lane_data(funct3, wdata);
          word_d  = 32'd0;
          to_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          word_d  = mem_rdata;
        end else if (cnt_inc_s == TO_LIMIT) begin
          // Abandoned access: report it and return an all-zero word.
          state_d = S_DONE;
          cnt_d   = cnt_inc_s;
          word_d  = 32'd0;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        to_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        to_d    = 1'b0;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      to_q    <= to_d;
    end
  end

  // Outputs: bus fields only while requesting, result only in DONE.
  always_comb begin
    stall     = 1'b0;
    misalign  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    rdata     = 32'd0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall    = access_s & ~bad_s;
        misalign = access_s & bad_s;
      end
      S_REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
      end
      S_DONE: begin
        timeout = to_q;
        if (!we_q) begin
          rdata = load_extend(f3_q, addr_q[1:0], word_q);
        end else begin
          rdata = 32'd0;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected DONE results are queued when an
// access is issued and compared when the unit leaves its request phase.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  load_store_unit #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .timeout   (timeout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; ack_dly < 0 means the bus never answers.
  task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] word, input int ack_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd, input logic exp_to);
    exp_t e;
    exp_t got;
    int   req_n;
    int   stall_n;
    int   exp_req;
    bit   done;
    @(negedge clk);
    rd_en  = !wr;
    wr_en  = wr;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
    mem_ack = 1'b0;
    e.rdata = exp_rd;
    e.to    = exp_to;
    sb.push_back(e);
    exp_req = (ack_dly < 0) ? 15 : ack_dly + 1;
    #1;
    chk("c0_stall", 32'(stall), 32'd1);
    chk("c0_misalign", 32'(misalign), 32'd0);
    chk("c0_req", 32'(mem_req), 32'd0);
    req_n   = 0;
    stall_n = 1;
    done    = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        req_n++;
        if (stall) stall_n++;
        chk("req_we", 32'(mem_we), 32'(wr));
        chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("req_be", 32'(mem_be), 32'(exp_be));
        if (wr) chk("req_wdata", mem_wdata, exp_wd);
        chk("req_rdata", rdata, 32'd0);
        chk("req_timeout", 32'(timeout), 32'd0);
        if (ack_dly >= 0 && req_n == ack_dly + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = word;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ack = 1'b0;
        done    = 1'b1;
        chk("done_stall", 32'(stall), 32'd0);
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          got = sb.pop_front();
          chk("done_rdata", rdata, got.rdata);
          chk("done_timeout", 32'(timeout), 32'(got.to));
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("req_cycles", 32'(req_n), 32'(exp_req));
    chk("stall_cycles", 32'(stall_n), 32'(exp_req + 1));
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    //          wr    f3      addr          wdata         word          dly  be       wdata_exp     rdata_exp     to
    run_access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    run_access(1'b0, 3'b001, 32'h0000_0042, 32'h0,         32'h1234_8001, 2, 4'b1100, 32'h0,        32'h0000_1234, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_0040, 32'h0,         32'h1234_F00F, 0, 4'b0011, 32'h0,        32'hFFFF_F00F, 1'b0);
    run_access(1'b0, 3'b101, 32'h0000_0040, 32'h0,         32'h1234_F00F, 1, 4'b0011, 32'h0,        32'h0000_F00F, 1'b0);
    run_access(1'b1, 3'b000, 32'h0000_0007, 32'h1122_335A, 32'h0,        0, 4'b1000, 32'h5A5A_5A5A, 32'h0,        1'b0);
    run_access(1'b0, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 3, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
    run_access(1'b1, 3'b011, 32'h0000_0010, 32'h0123_4567, 32'h0,        0, 4'b1111, 32'h0123_4567, 32'h0,        1'b0);
    run_access(1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0,        32'h0000_007F, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_0040, 32'h0,         32'h0,        -1, 4'b0011, 32'h0,        32'h0,        1'b1);

    // Misaligned word load and halfword store are dropped without a bus access.
    @(negedge clk);
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0101;
    #1;
    chk("mis_lw_flag", 32'(misalign), 32'd1);
    chk("mis_lw_stall", 32'(stall), 32'd0);
    chk("mis_lw_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("mis_lw_req", 32'(mem_req), 32'd0);
    rd_en = 1'b0; wr_en = 1'b1; funct3 = 3'b001; addr = 32'h0000_0023;
    #1;
    chk("mis_sh_flag", 32'(misalign), 32'd1);
    @(negedge clk);
    chk("mis_sh_req", 32'(mem_req), 32'd0);
    wr_en = 1'b0;

    // Reset in the second REQ cycle; the late ack must not produce a DONE.
    @(negedge clk);
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0200;
    @(negedge clk);
    chk("rr_req1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rr_req2", 32'(mem_req), 32'd1);
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    chk("rr_req_after", 32'(mem_req), 32'd0);
    chk("rr_stall_after", 32'(stall), 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_late_req", 32'(mem_req), 32'd0);
      chk("rr_late_rdata", rdata, 32'd0);
      chk("rr_late_timeout", 32'(timeout), 32'd0);
    end
    mem_ack = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
